// File: rtl/dsp48e_round_pkg.sv
// Shared widths of the DSP48E convergent-rounding MAC path and the signed saturation limits
// used by the round_result_collector receive stage.
package dsp48e_round_pkg;

    localparam int ROUND_W = 44;
    localparam int A_W     = 25;
    localparam int B_W     = 18;
    localparam int C_W     = 48;

    function automatic logic signed [63:0] sat_max(input int out_w);
        return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int out_w);
        return -(64'sd1 <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/round_result_collector_if.sv
// Handshake/status bundle between the DSP rounding path, the collector and downstream fabric.
// The slave modport is the collector itself.
interface round_result_collector_if
    import dsp48e_round_pkg::*;
#(
    parameter int IN_W  = ROUND_W,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic [IN_W-1:0]  round_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             almost_full;
    logic             overflow;
    logic [15:0]      sat_count;
    logic [15:0]      drop_count;

    modport master (
        output in_valid, round_in, out_ready,
        input  out_valid, out_data, out_sat, almost_full, overflow, sat_count, drop_count
    );

    modport slave (
        input  in_valid, round_in, out_ready,
        output out_valid, out_data, out_sat, almost_full, overflow, sat_count, drop_count
    );

endinterface

// File: rtl/round_sat_fifo.sv
// Synchronous FIFO for {sat, sample} words: occupancy count, registered almost-full flag
// and a drop strobe for writes that find the FIFO full with no simultaneous pop.
module round_sat_fifo #(
    parameter int W        = 17,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic         almost_full,
    output logic         wr_drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          pop;
    logic          push;

    assign rd_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push     = wr_en && (!full || pop);
    assign wr_drop  = wr_en && full && !pop;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count       <= count_next;
            almost_full <= (count_next >= CW'(AF_LEVEL));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/round_result_collector.sv
// Receive end of the DSP48E rounding MAC path: drop DROP LSBs, saturate to OUT_W, buffer in FIFO.
// Define ROUND_COLLECT_STATS_EN to enable the saturating SAT_COUNT/DROP_COUNT event counters.
module round_result_collector
    import dsp48e_round_pkg::*;
#(
    parameter int IN_W     = ROUND_W,
    parameter int DROP     = 4,
    parameter int OUT_W    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input logic                     clk,
    input logic                     rst,
    round_result_collector_if.slave bus
);
    localparam logic signed [IN_W-1:0] SAT_HI  = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0] SAT_LO  = IN_W'(sat_min(OUT_W));
    localparam logic [OUT_W-1:0]       OUT_MAX = OUT_W'(sat_max(OUT_W));
    localparam logic [OUT_W-1:0]       OUT_MIN = OUT_W'(sat_min(OUT_W));

    logic signed [IN_W-1:0] shifted;
    logic [OUT_W-1:0]       sat_data;
    logic                   sat_flag;
    logic                   stage_valid;
    logic [OUT_W-1:0]       stage_data;
    logic                   stage_sat;
    logic [OUT_W:0]         head;
    logic                   wr_drop;
    logic                   overflow;

    // Upstream already rounded at bit DROP, so a plain arithmetic shift is exact here.
    assign shifted = $signed(bus.round_in) >>> DROP;

    always_comb begin
        sat_data = shifted[OUT_W-1:0];
        sat_flag = 1'b0;
        if (shifted > SAT_HI) begin
            sat_data = OUT_MAX;
            sat_flag = 1'b1;
        end else if (shifted < SAT_LO) begin
            sat_data = OUT_MIN;
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
            stage_sat   <= 1'b0;
        end else begin
            stage_valid <= bus.in_valid;
            if (bus.in_valid) begin
                stage_data <= sat_data;
                stage_sat  <= sat_flag;
            end
        end
    end

    round_sat_fifo #(
        .W        (OUT_W + 1),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (stage_valid),
        .wr_data     ({stage_sat, stage_data}),
        .rd_ready    (bus.out_ready),
        .rd_valid    (bus.out_valid),
        .rd_data     (head),
        .almost_full (bus.almost_full),
        .wr_drop     (wr_drop)
    );

    assign bus.out_sat  = head[OUT_W];
    assign bus.out_data = head[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end
    end

    assign bus.overflow = overflow;

`ifdef ROUND_COLLECT_STATS_EN
    logic [15:0] sat_cnt;
    logic [15:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (stage_valid && stage_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
            if (wr_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign bus.sat_count  = sat_cnt;
    assign bus.drop_count = drop_cnt;
`else
    assign bus.sat_count  = '0;
    assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_round_result_collector.sv
// Bench for round_result_collector: vector table, directed FIFO corner sequences and
// randomized traffic against a queue-based reference model.
module tb_round_result_collector;

`ifdef ROUND_COLLECT_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    round_result_collector_if #(.IN_W(44), .OUT_W(16)) bus ();

    round_result_collector #(
        .IN_W(44), .DROP(4), .OUT_W(16), .DEPTH(8), .AF_LEVEL(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [43:0] din;
        logic [15:0] dout;
        logic        sat;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [16:0] q[$];
    logic        m_stage_v;
    logic [15:0] m_stage_d;
    logic        m_stage_sat;
    logic        m_ovf;
    logic [15:0] m_satc;
    logic [15:0] m_dropc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] stat_exp(input logic [15:0] v);
        return STATS_ON ? v : 16'd0;
    endfunction

    // Reference: value/16 rounded toward -inf, clamped to the signed 16-bit range.
    function automatic void ref_sat(input logic [43:0] x, output logic [15:0] d, output logic s);
        longint v;
        longint qv;
        v  = longint'($signed(x));
        qv = v >>> 4;
        if (qv > 32767) begin
            d = 16'h7FFF; s = 1'b1;
        end else if (qv < -32768) begin
            d = 16'h8000; s = 1'b1;
        end else begin
            d = qv[15:0]; s = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_stage_v = 1'b0;
            m_ovf     = 1'b0;
            m_satc    = '0;
            m_dropc   = '0;
        end else begin
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (m_stage_v) begin
                if (m_stage_sat && m_satc != 16'hFFFF) m_satc++;
                if (q.size() < 8) q.push_back({m_stage_sat, m_stage_d});
                else begin
                    m_ovf = 1'b1;
                    if (m_dropc != 16'hFFFF) m_dropc++;
                end
            end
            m_stage_v = bus.in_valid;
            if (bus.in_valid) ref_sat(bus.round_in, m_stage_d, m_stage_sat);
        end
        #1;
        check("m_out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("m_out_data", bus.out_data, q[0][15:0]);
            check("m_out_sat", bus.out_sat, q[0][16]);
        end
        check("m_almost_full", bus.almost_full, q.size() >= 6);
        check("m_overflow", bus.overflow, m_ovf);
        check("m_sat_count", bus.sat_count, stat_exp(m_satc));
        check("m_drop_count", bus.drop_count, stat_exp(m_dropc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.out_ready = 1'b1;
            check("drain_valid", bus.out_valid, 1);
            check("drain_data", bus.out_data, 16'(first + i));
            step();
        end
        bus.out_ready = 1'b0;
        check("drain_empty", bus.out_valid, 0);
    endtask

    initial begin
        vec_t vecs[9];
        int   n_sat_vec;
        int   first_af;
        int   n_out;
        logic [63:0] r64;
        longint sv;

        vecs[0] = '{44'h0000_0001_230, 16'h0123, 1'b0};
        vecs[1] = '{44'h000_0010_0000, 16'h7FFF, 1'b1};
        vecs[2] = '{44'hFFF_FFF0_0000, 16'h8000, 1'b1};
        vecs[3] = '{44'hFFF_FFFF_FFF0, 16'hFFFF, 1'b0};
        vecs[4] = '{44'h000_0007_FFF0, 16'h7FFF, 1'b0};
        vecs[5] = '{44'h000_0007_FFFF, 16'h7FFF, 1'b0};
        vecs[6] = '{44'h000_0008_0000, 16'h7FFF, 1'b1};
        vecs[7] = '{44'hFFF_FFF8_0000, 16'h8000, 1'b0};
        vecs[8] = '{44'hFFF_FFF7_FFFF, 16'h8000, 1'b1};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.round_in  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sat", bus.out_sat, 0);
        check("rst_almost_full", bus.almost_full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_sat_count", bus.sat_count, 0);
        check("rst_drop_count", bus.drop_count, 0);

        // Single words: two-cycle latency, popped the cycle after they appear.
        n_sat_vec = 0;
        for (int i = 0; i < 9; i++) begin
            bus.round_in  = vecs[i].din;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            step();
            bus.in_valid = 1'b0;
            check("vec_not_early", bus.out_valid, 0);
            step();
            check("vec_valid", bus.out_valid, 1);
            check("vec_data", bus.out_data, vecs[i].dout);
            check("vec_sat", bus.out_sat, vecs[i].sat);
            step();
            check("vec_popped", bus.out_valid, 0);
            if (vecs[i].sat) n_sat_vec++;
        end
        check("vec_sat_count", bus.sat_count, STATS_ON ? 16'(n_sat_vec) : 16'd0);
        bus.out_ready = 1'b0;

        // Full FIFO with write and pop on the same edge: accepted, nothing dropped.
        do_reset();
        for (int t = 1; t <= 9; t++) begin
            bus.in_valid = 1'b1;
            bus.round_in = 44'(t) << 4;
            step();
        end
        check("full_af", bus.almost_full, 1);
        check("full_head", bus.out_data, 16'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("full_pop_overflow", bus.overflow, 0);
        check("full_pop_drops", bus.drop_count, 0);
        check("full_pop_af", bus.almost_full, 1);
        check("full_pop_head", bus.out_data, 16'd2);
        drain(2, 8);

        // Ten back-to-back words with no reader: 8 kept, 2 dropped.
        do_reset();
        first_af = -1;
        for (int t = 1; t <= 12; t++) begin
            bus.in_valid = (t <= 10);
            bus.round_in = 44'(t) << 4;
            step();
            if (first_af < 0 && bus.almost_full) first_af = t;
        end
        check("af_rise_step", 64'(first_af), 64'd7);
        check("ovf_overflow", bus.overflow, 1);
        check("ovf_drop_count", bus.drop_count, STATS_ON ? 16'd2 : 16'd0);
        drain(1, 8);
        check("ovf_sticky", bus.overflow, 1);

        // Reset with 5 stored words and a live stage word.
        for (int t = 1; t <= 6; t++) begin
            bus.in_valid = 1'b1;
            bus.round_in = 44'(16'h40 + t) << 4;
            step();
        end
        check("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_overflow", bus.overflow, 0);
        check("mid_rst_af", bus.almost_full, 0);
        check("mid_rst_drops", bus.drop_count, 0);
        step();
        step();
        check("post_rst_no_stage", bus.out_valid, 0);

        // Randomized traffic: slow reader then fast reader.
        for (int t = 0; t < 400; t++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = (t < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            r64 = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1) begin
                sv  = longint'($urandom_range(0, 32'h0020_0000)) - 64'sh0010_0000;
                r64 = sv;
            end
            bus.round_in = r64[43:0];
            step();
        end

        // Streaming at one sample per clock.
        do_reset();
        bus.out_ready = 1'b1;
        n_out = 0;
        for (int t = 0; t < 34; t++) begin
            bus.in_valid = (t < 32);
            bus.round_in = 44'(t) << 4;
            step();
            if (bus.out_valid) begin
                check("stream_data", bus.out_data, 16'(n_out));
                n_out++;
            end
        end
        check("stream_count", 64'(n_out), 64'd32);
        check("stream_overflow", bus.overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
